mem_stage: RTL

- Memory-access stage of the 5-stage in-order pipeline. Sits between EX and WB.
- Accepts an instruction from EX and waits for the data-SRAM response when the instruction is a load. Extracts and extends the load data, then forwards {pc, dest, final_result, gr_we} to WB.
- Also drives a forwarding bus back to ID for bypass and load-use interlock.

---
 rtl/mem_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: waits for load data, extracts and extends it,
// hands the result to WB and exposes a bypass/interlock bus to ID.
module mem_stage #(
    parameter int TO_MEM_W = 74,
    parameter int TO_WB_W  = 70,
    parameter int FWD_W    = 40
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                EX_to_MEM_valid,
    input  logic [TO_MEM_W-1:0] to_MEM_data,
    output logic                MEM_allow_in,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    output logic                MEM_to_WB_valid,
    output logic [TO_WB_W-1:0]  to_WB_data,
    input  logic                WB_allow_in,
    output logic [FWD_W-1:0]    MEM_fwd_bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic        gr_we;
        logic        res_from_mem;
        logic [2:0]  mem_op;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic        gr_we;
    } mem_wb_t;

    logic        mem_valid;
    ex_mem_t     mem_r;
    logic [31:0] rdata_buf;
    logic        rdata_buf_valid;

    logic        need_data;
    logic        ready_go;
    logic        leave;
    logic        buf_capture;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] final_result;
    logic        is_b;
    logic        is_bu;
    logic        is_h;
    logic        is_hu;
    mem_wb_t     wb_out;

    assign need_data       = mem_valid & mem_r.res_from_mem;
    assign ready_go        = ~need_data | data_sram_data_ok | rdata_buf_valid;
    assign MEM_to_WB_valid = mem_valid & ready_go;
    assign MEM_allow_in    = ~mem_valid | (ready_go & WB_allow_in);
    assign leave           = MEM_to_WB_valid & WB_allow_in;

    // A response that WB cannot take yet must survive until handoff.
    assign buf_capture = need_data & data_sram_data_ok
                       & ~rdata_buf_valid & ~WB_allow_in;

    assign is_b  = mem_r.mem_op == 3'b001;
    assign is_bu = mem_r.mem_op == 3'b101;
    assign is_h  = mem_r.mem_op == 3'b010;
    assign is_hu = mem_r.mem_op == 3'b110;

    always_comb begin
        ld_word = rdata_buf_valid ? rdata_buf : data_sram_rdata;
        ld_byte = ld_word[7:0];
        unique case (mem_r.alu_result[1:0])
            2'b00: ld_byte = ld_word[7:0];
            2'b01: ld_byte = ld_word[15:8];
            2'b10: ld_byte = ld_word[23:16];
            2'b11: ld_byte = ld_word[31:24];
        endcase
        ld_half = mem_r.alu_result[1] ? ld_word[31:16] : ld_word[15:0];
        unique case (1'b1)
            is_b:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            is_bu:   ld_data = {24'd0, ld_byte};
            is_h:    ld_data = {{16{ld_half[15]}}, ld_half};
            is_hu:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    assign final_result = mem_r.res_from_mem ? ld_data : mem_r.alu_result;

    always_comb begin
        wb_out.pc           = mem_r.pc;
        wb_out.dest         = mem_r.dest;
        wb_out.final_result = final_result;
        wb_out.gr_we        = mem_r.gr_we;
    end

    assign to_WB_data = wb_out;

    assign MEM_fwd_bus = {
        mem_valid,
        mem_r.gr_we & mem_valid & (mem_r.dest != 5'd0),
        mem_r.dest,
        final_result,
        need_data & ~ready_go
    };

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid       <= 1'b0;
            mem_r           <= '0;
            rdata_buf       <= '0;
            rdata_buf_valid <= 1'b0;
        end else begin
            if (MEM_allow_in) begin
                mem_valid <= EX_to_MEM_valid;
            end
            if (MEM_allow_in && EX_to_MEM_valid) begin
                mem_r <= to_MEM_data;
            end
            if (leave) begin
                rdata_buf_valid <= 1'b0;
            end else if (buf_capture) begin
                rdata_buf_valid <= 1'b1;
                rdata_buf       <= data_sram_rdata;
            end
        end
    end

endmodule
